// File: rtl/lif_scheduler_if.sv
// Current-write handshake bundle for lif_scheduler: the host offers a current
// value for one neuron; the scheduler accepts it only while idle.
interface lif_scheduler_if;
  logic       cur_valid;
  logic       cur_ready;
  logic [1:0] cur_id;
  logic [7:0] cur_data;

  modport master (
    output cur_valid,
    output cur_id,
    output cur_data,
    input  cur_ready
  );

  modport slave (
    input  cur_valid,
    input  cur_id,
    input  cur_data,
    output cur_ready
  );
endinterface

// File: rtl/lif_scheduler.sv
// Four-neuron leaky integrate-and-fire scheduler. A step request starts a
// sweep in which a single shared update datapath visits neurons 0..3 on four
// consecutive edges: spike test on the pre-update membrane, leaky integration
// of the buffered current with saturation, optional threshold adaptation, and
// consumption of the current buffer. Spike flags of the sweep are published
// together with a one-cycle done pulse at the neuron-3 edge.
module lif_scheduler #(
  parameter int BETA        = 224,
  parameter int THRESH_INIT = 100,
  parameter int THR_STEP    = 16,
  parameter int THR_MIN     = 32,
  parameter int THR_MAX     = 220
) (
  input  logic                clk,
  input  logic                rst,
  lif_scheduler_if.slave      cur,
  input  logic                step,
  input  logic                learn_en,
  output logic                busy,
  output logic                done,
  output logic [3:0]          spike_vec,
  output logic                step_err,
  input  logic [1:0]          rd_id,
  output logic [7:0]          rd_state
);

  localparam logic [7:0] BETA_U8     = 8'(BETA);
  localparam logic [7:0] THR_INIT_U8 = 8'(THRESH_INIT);
  localparam logic [7:0] THR_STEP_U8 = 8'(THR_STEP);
  localparam logic [7:0] THR_MIN_U8  = 8'(THR_MIN);
  localparam logic [7:0] THR_MAX_U8  = 8'(THR_MAX);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_UPDATE = 1'b1;

  // Membrane leak: state * BETA / 256 with a 16-bit product.
  function automatic logic [7:0] leak(input logic [7:0] st);
    logic [15:0] prod;
    prod = 16'(st) * 16'(BETA_U8);
    return prod[15:8];
  endfunction

  // Integration with saturation at 255, evaluated on a 16-bit intermediate.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] sum;
    sum = 16'(a) + 16'(b);
    return (sum > 16'd255) ? 8'hFF : sum[7:0];
  endfunction

  // Threshold adaptation: climb by THR_STEP on a spike (capped at THR_MAX),
  // otherwise relax by one (floored at THR_MIN).
  function automatic logic [7:0] thr_adapt(input logic [7:0] thr, input logic spk);
    logic [8:0] up;
    logic [7:0] res;
    up = {1'b0, thr} + {1'b0, THR_STEP_U8};
    if (spk) begin
      res = (up > {1'b0, THR_MAX_U8}) ? THR_MAX_U8 : up[7:0];
    end else begin
      res = (thr > THR_MIN_U8) ? (thr - 8'd1) : THR_MIN_U8;
    end
    return res;
  endfunction

  logic [0:0] fsm_q;
  logic [1:0] idx_q;
  logic [2:0] spk_acc_q;

  logic [7:0] state_q [0:3];
  logic [7:0] thr_q   [0:3];
  logic [7:0] buf_q   [0:3];
  logic [7:0] state_nxt [0:3];

  logic       wr_acc;
  logic [7:0] state_p0;
  logic [7:0] thr_p0;
  logic [7:0] buf_p0;
  logic       spike_p0;
  logic [7:0] new_state_p0;
  logic [7:0] new_thr_p0;

  assign busy          = (fsm_q == S_UPDATE);
  assign cur.cur_ready = ~busy;
  assign wr_acc        = cur.cur_valid & cur.cur_ready;

  // Shared update datapath: operands of the neuron selected by the sweep index.
  always_comb begin
    state_p0     = state_q[idx_q];
    thr_p0       = thr_q[idx_q];
    buf_p0       = buf_q[idx_q];
    spike_p0     = (state_p0 >= thr_p0);
    new_state_p0 = spike_p0 ? 8'd0 : sat_add(buf_p0, leak(state_p0));
    new_thr_p0   = thr_adapt(thr_p0, spike_p0);
  end

  // Post-edge membrane values, shared by the state registers and the readback.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_nxt[i] = state_q[i];
    end
    if (busy) begin
      state_nxt[idx_q] = new_state_p0;
    end
  end

  // Sweep sequencer: IDLE waits for step, UPDATE walks neurons 0..3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= S_IDLE;
      idx_q <= 2'd0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (step) begin
            fsm_q <= S_UPDATE;
            idx_q <= 2'd0;
          end
        end
        default: begin
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            fsm_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Spike collection, done pulse, published spike vector and sticky step error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spk_acc_q <= 3'd0;
      spike_vec <= 4'd0;
      done      <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy && step) begin
        step_err <= 1'b1;
      end
      if (busy) begin
        if (idx_q == 2'd3) begin
          spike_vec <= {spike_p0, spk_acc_q};
          done      <= 1'b1;
        end else begin
          spk_acc_q[idx_q] <= spike_p0;
        end
      end
    end
  end

  // Membrane state registers and registered readback of the selected neuron.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= 8'd0;
      end
      rd_state <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_nxt[i];
      end
      rd_state <= state_nxt[rd_id];
    end
  end

  // Adaptive thresholds, touched only for the neuron being updated with learning on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        thr_q[i] <= THR_INIT_U8;
      end
    end else if (busy && learn_en) begin
      thr_q[idx_q] <= new_thr_p0;
    end
  end

  // Current buffers: host writes while idle, consumed when the neuron is updated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= 8'd0;
      end
    end else begin
      if (wr_acc) begin
        buf_q[cur.cur_id] <= cur.cur_data;
      end
      if (busy) begin
        buf_q[idx_q] <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_lif_scheduler.sv
// Bench for lif_scheduler: directed scenarios followed by randomized sweeps,
// all checked against a sweep-level behavioural model of the four neurons.
module tb_lif_scheduler;

  localparam int BETA        = 224;
  localparam int THRESH_INIT = 100;
  localparam int THR_STEP    = 16;
  localparam int THR_MIN     = 32;
  localparam int THR_MAX     = 220;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       step = 1'b0;
  logic       learn_en = 1'b0;
  logic [1:0] rd_id = 2'd0;
  logic       busy;
  logic       done;
  logic [3:0] spike_vec;
  logic       step_err;
  logic [7:0] rd_state;

  lif_scheduler_if cif ();

  lif_scheduler #(
    .BETA(BETA), .THRESH_INIT(THRESH_INIT), .THR_STEP(THR_STEP),
    .THR_MIN(THR_MIN), .THR_MAX(THR_MAX)
  ) dut (
    .clk(clk), .rst(rst), .cur(cif), .step(step), .learn_en(learn_en),
    .busy(busy), .done(done), .spike_vec(spike_vec), .step_err(step_err),
    .rd_id(rd_id), .rd_state(rd_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model of the neuron population.
  int       m_state [4];
  int       m_thr   [4];
  int       m_buf   [4];
  bit [3:0] m_spk;
  bit       m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_state[i] = 0;
      m_thr[i]   = THRESH_INIT;
      m_buf[i]   = 0;
    end
    m_spk = 4'd0;
    m_err = 1'b0;
  endfunction

  function automatic void model_sweep(input bit learn);
    for (int i = 0; i < 4; i++) begin
      bit sp;
      int v;
      sp = (m_state[i] >= m_thr[i]);
      if (sp) m_state[i] = 0;
      else begin
        v = m_buf[i] + (m_state[i] * BETA) / 256;
        m_state[i] = (v > 255) ? 255 : v;
      end
      if (learn) begin
        if (sp) m_thr[i] = (m_thr[i] + THR_STEP > THR_MAX) ? THR_MAX : m_thr[i] + THR_STEP;
        else    m_thr[i] = (m_thr[i] - 1 < THR_MIN) ? THR_MIN : m_thr[i] - 1;
      end
      m_buf[i] = 0;
      m_spk[i] = sp;
    end
  endfunction

  task automatic write_cur(input int id, input int d);
    cif.cur_valid = 1'b1;
    cif.cur_id    = 2'(id);
    cif.cur_data  = 8'(d);
    @(posedge clk); #1;
    cif.cur_valid = 1'b0;
    m_buf[id] = d;
  endtask

  task automatic read_state(input int id, output int v);
    rd_id = 2'(id);
    @(posedge clk); #1;
    v = int'(rd_state);
  endtask

  task automatic check_state(input int id, input string tag);
    int v;
    read_state(id, v);
    chk(tag, v, m_state[id]);
  endtask

  // One full sweep with timing checks; optional same-edge write, step poke
  // while busy, and an attempted write while busy that must be dropped.
  task automatic run_sweep(input bit learn, input bit poke, input bit wr,
                           input int wid, input int wd, input bit busy_wr);
    step = 1'b1;
    learn_en = learn;
    if (wr) begin
      cif.cur_valid = 1'b1;
      cif.cur_id    = 2'(wid);
      cif.cur_data  = 8'(wd);
    end
    @(posedge clk); #1;
    step = 1'b0;
    cif.cur_valid = 1'b0;
    if (wr) m_buf[wid] = wd;
    for (int c = 0; c < 4; c++) begin
      chk("busy_in_sweep", busy, 1);
      chk("ready_in_sweep", cif.cur_ready, 0);
      chk("done_early", done, 0);
      if (c == 0 && poke) step = 1'b1;
      if (c == 1 && busy_wr) begin
        cif.cur_valid = 1'b1;
        cif.cur_id    = 2'($urandom_range(0, 3));
        cif.cur_data  = 8'($urandom_range(1, 255));
      end
      @(posedge clk); #1;
      step = 1'b0;
      cif.cur_valid = 1'b0;
    end
    model_sweep(learn);
    if (poke) m_err = 1'b1;
    chk("done_pulse", done, 1);
    chk("busy_after", busy, 0);
    chk("ready_after", cif.cur_ready, 1);
    chk("spike_vec", spike_vec, m_spk);
    chk("step_err", step_err, m_err);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("spike_vec_held", spike_vec, m_spk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  int v;
  int exp_int [4] = '{50, 93, 131, 0};

  initial begin
    cif.cur_valid = 1'b0;
    cif.cur_id    = 2'd0;
    cif.cur_data  = 8'd0;
    model_reset();

    // Power-on reset values.
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", cif.cur_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_spike_vec", spike_vec, 0);
    chk("rst_step_err", step_err, 0);
    chk("rst_rd_state", rd_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Integration with learning off.
    for (int k = 0; k < 4; k++) begin
      write_cur(0, 50);
      run_sweep(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      read_state(0, v);
      chk("int_state_n0", v, exp_int[k]);
      chk("int_spike_n0", spike_vec[0], (k == 3) ? 1 : 0);
    end

    // Saturation on neuron 1.
    write_cur(1, 50);
    run_sweep(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    read_state(1, v);
    chk("sat_first", v, 50);
    write_cur(1, 255);
    run_sweep(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    read_state(1, v);
    chk("sat_second", v, 255);
    chk("sat_no_spike", spike_vec[1], 0);

    // Adaptation: same stimulus as integration, learning on.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      write_cur(0, 50);
      run_sweep(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      check_state(0, "adapt_state_n0");
    end
    // Threshold of neuron 0 is now 113: a membrane of 112 must not spike.
    write_cur(0, 112);
    run_sweep(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_sweep(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("thr113_no_spike", spike_vec[0], 0);
    // 64 more learning sweeps bring idle neuron 2 to the floor of 32.
    for (int k = 0; k < 64; k++) begin
      run_sweep(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    end
    write_cur(2, 32);
    run_sweep(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    check_state(2, "floor_state_n2");
    run_sweep(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("floor_spike_n2", spike_vec[2], 1);

    // Step while busy sets the sticky error; same-edge write is consumed.
    run_sweep(1'b0, 1'b1, 1'b1, 3, 77, 1'b1);
    check_state(3, "same_edge_write_n3");
    run_sweep(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("step_err_sticky", step_err, 1);

    // Reset in the second UPDATE cycle aborts the sweep.
    write_cur(2, 99);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_spike_vec", spike_vec, 0);
    chk("mid_rst_step_err", step_err, 0);
    chk("mid_rst_rd_state", rd_state, 0);
    @(posedge clk); #1;
    chk("mid_rst_no_done", done, 0);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) check_state(i, "mid_rst_state");
    // Thresholds back at 100: 100 spikes, 99 does not.
    write_cur(0, 100);
    write_cur(2, 99);
    run_sweep(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_sweep(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("post_rst_spike_n0", spike_vec[0], 1);
    chk("post_rst_spike_n2", spike_vec[2], 0);

    // Randomized sweeps against the model.
    for (int k = 0; k < 40; k++) begin
      int nw;
      nw = $urandom_range(0, 2);
      for (int j = 0; j < nw; j++) write_cur($urandom_range(0, 3), $urandom_range(0, 255));
      run_sweep(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 255),
                1'($urandom_range(0, 1)));
      check_state($urandom_range(0, 3), "rand_state");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lif_scheduler.md
LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 SHALL have parameter BETA, default 224, decay factor in 1/256 units.
REQ-002 SHALL have parameter THRESH_INIT, default 100, per-neuron threshold after reset.
REQ-003 SHALL have parameter THR_STEP, default 16, threshold increase applied on each spike when learning.
REQ-004 SHALL have parameters THR_MIN, default 32, and THR_MAX, default 220, the adaptive threshold bounds.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port cur_valid  input  1  current-write request.
REQ-008 SHALL have port cur_ready  output  1  current-write accept; high only in IDLE.
REQ-009 SHALL have port cur_id  input  2  target neuron index 0..3.
REQ-010 SHALL have port cur_data  input  8  unsigned input current.
REQ-011 SHALL have port step  input  1  request one update sweep over all 4 neurons.
REQ-012 SHALL have port learn_en  input  1  enables adaptive threshold, sampled per neuron update.
REQ-013 SHALL have port busy  output  1  high while sweep in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse, sweep complete.
REQ-015 SHALL have port spike_vec  output  4  spike flags of the last completed sweep, bit i = neuron i.
REQ-016 SHALL have port step_err  output  1  sticky flag, step requested while busy.
REQ-017 SHALL have port rd_id  input  2  readback neuron select.
REQ-018 SHALL have port rd_state  output  8  membrane state of neuron rd_id, registered, 1-cycle latency.

Function
REQ-019 SHALL hold per neuron: 8-bit state, 8-bit threshold, 8-bit current buffer; one shared update datapath used by one neuron per cycle.
REQ-020 SHALL implement FSM IDLE and UPDATE; IDLE->UPDATE when step=1 at an edge; UPDATE processes neurons 0,1,2,3 on four consecutive edges; UPDATE->IDLE at the edge updating neuron 3.
REQ-021 SHALL accept a current write when cur_valid && cur_ready at an edge, overwriting buffer[cur_id]; writes in the same cycle step is sampled land before the sweep and are used by it.
REQ-022 SHALL per neuron update: spike = (state >= threshold) on the pre-update state; if spike, state <= 0; else state <= min(255, current + ((state*BETA)>>8)), 16-bit intermediate, saturating.
REQ-023 SHALL when learn_en=1 on a neuron update: spike -> threshold <= min(threshold+THR_STEP, THR_MAX); no spike -> threshold <= max(threshold-1, THR_MIN); learn_en=0 -> threshold unchanged.
REQ-024 SHALL clear buffer[i] to 0 when neuron i is updated; unwritten neurons integrate current 0.
REQ-025 SHALL collect spikes during the sweep and load spike_vec and assert done at the neuron-3 edge; done visible exactly 4 cycles after the step-sampling edge, high one cycle; spike_vec held until next done.
REQ-026 SHALL drive busy = (FSM == UPDATE), cur_ready = !busy.
REQ-027 SHALL ignore step while busy and set step_err until reset; a step in the first IDLE cycle after done starts a new sweep.
REQ-028 SHALL update rd_state every cycle from the post-edge state of neuron rd_id.

Reset
REQ-029 SHALL on rst=1, asynchronously: FSM IDLE, all states 0, all thresholds THRESH_INIT, all buffers 0, busy 0, cur_ready 1, done 0, spike_vec 0, step_err 0, rd_state 0.
REQ-030 SHALL on rst during UPDATE abort the sweep with no done pulse and all REQ-029 values; first step after rst release starts a full sweep from neuron 0.

Verification
REQ-031 SHALL verify integration: learn_en=0, write neuron0=50 before each of 4 steps -> state 50, 93, 131, then step 4 spike_vec=0001, state 0.
REQ-032 SHALL verify saturation: neuron1 currents 50 then 255 on two steps -> state 50, then 255, no spike.
REQ-033 SHALL verify adaptation: learn_en=1, REQ-031 stimulus -> neuron0 threshold 99, 98, 97, then 113 after the spike; idle neuron2 reaches 32 after 68 steps and holds.
REQ-034 SHALL verify handshake/timing: step at edge E0 -> busy cycles E0..E3, done high only after E3, cur_ready low while busy, step at E1 sets step_err=1.
REQ-035 SHALL verify reset mid-sweep: rst at 2nd UPDATE cycle -> no done, spike_vec 0, thresholds 100, rd_state 0; next step completes normally.
